// File: rtl/opentrig_pkg.sv
// Shared types for the trigger/ID serial transmitter.
// Holds the frame FSM state encoding and default ID width.
package opentrig_pkg;

  localparam int ID_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_SHIFT,
    ST_GAP
  } trig_state_e;

endpackage

// File: rtl/bitclk_gen.sv
// Free-running bit clock divider for trig_id_tx.
// Ports: clk_i, rst_ni (async low), clk_o (bit clock), bnd_o (bit boundary strobe).
module bitclk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic clk_o,
  output logic bnd_o
);

  localparam int DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);

  logic [DW-1:0] div_q;
  logic          clk_q;

  // clk_q reflects div_q one cycle late, so the edge where div_q==0
  // is exactly the edge where clk_o rises.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_q <= '0;
      clk_q <= 1'b0;
    end else begin
      div_q <= (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
      clk_q <= (div_q < DIV_HALF);
    end
  end

  assign clk_o = clk_q;
  assign bnd_o = (div_q == '0);

endmodule

// File: rtl/trig_id_tx.sv
// Trigger pulse + serial ID transmitter with one-deep request queue.
// Ports: pll_clk, reset (async low), trig_req, id_src, trig_id_val, veto_in,
//        clk_out, trig_out, trig_id, busy, frame_done, id_sent, drop_count.
module trig_id_tx
  import opentrig_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int GAP_BITS = 4,
  parameter int ID_WIDTH = ID_W_DEF
) (
  input  logic                pll_clk,
  input  logic                reset,
  input  logic                trig_req,
  input  logic                id_src,
  input  logic [ID_WIDTH-1:0] trig_id_val,
  input  logic                veto_in,
  output logic                clk_out,
  output logic                trig_out,
  output logic                trig_id,
  output logic                busy,
  output logic                frame_done,
  output logic [ID_WIDTH-1:0] id_sent,
  output logic [7:0]          drop_count
);

  localparam int BW = $clog2(ID_WIDTH);
  localparam int GW = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(ID_WIDTH - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_BITS - 1);

  logic bnd;

  bitclk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_bclk (
    .clk_i (pll_clk),
    .rst_ni(reset),
    .clk_o (clk_out),
    .bnd_o (bnd)
  );

  trig_state_e         st_q;
  logic [ID_WIDTH-1:0] sh_q, id_q, cnt_q, pend_q, sent_q;
  logic                src_q, pend_src_q, pend_v_q;
  logic [BW-1:0]       bit_q;
  logic [GW-1:0]       gap_q;
  logic                trig_q, tid_q, busy_q, done_q;
  logic [7:0]          drop_q;

  logic                req_ok, gap_end, pend_take, gap_free;
  logic                ld_src;
  logic [ID_WIDTH-1:0] new_id, pend_id, ld_id;

  assign req_ok    = trig_req & ~veto_in;
  assign new_id    = id_src ? cnt_q : trig_id_val;
  // A queued counter request takes the counter value at launch, so
  // back-to-back counter frames never repeat an ID.
  assign pend_id   = pend_src_q ? cnt_q : pend_q;
  assign gap_end   = (st_q == ST_GAP) & bnd & (gap_q == GAP_LAST);
  assign pend_take = gap_end & pend_v_q;
  // Gap ends with nothing queued: a request this cycle launches directly.
  assign gap_free  = gap_end & ~pend_v_q;
  assign ld_id     = pend_v_q ? pend_id : new_id;
  assign ld_src    = pend_v_q ? pend_src_q : id_src;

  always_ff @(posedge pll_clk or negedge reset) begin
    if (!reset) begin
      st_q       <= ST_IDLE;
      sh_q       <= '0;
      id_q       <= '0;
      cnt_q      <= '0;
      pend_q     <= '0;
      sent_q     <= '0;
      src_q      <= 1'b0;
      pend_src_q <= 1'b0;
      pend_v_q   <= 1'b0;
      bit_q      <= '0;
      gap_q      <= '0;
      trig_q     <= 1'b0;
      tid_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      drop_q     <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (st_q)
        ST_IDLE: begin
          if (req_ok) begin
            sh_q   <= new_id;
            id_q   <= new_id;
            src_q  <= id_src;
            busy_q <= 1'b1;
            st_q   <= ST_ARMED;
          end
        end
        ST_ARMED: begin
          if (bnd) begin
            trig_q <= 1'b1;
            tid_q  <= sh_q[ID_WIDTH-1];
            sh_q   <= sh_q << 1;
            bit_q  <= '0;
            st_q   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (bnd) begin
            trig_q <= 1'b0;
            if (bit_q == BIT_LAST) begin
              tid_q  <= 1'b0;
              done_q <= 1'b1;
              sent_q <= id_q;
              if (src_q) cnt_q <= cnt_q + 1'b1;
              gap_q  <= '0;
              st_q   <= ST_GAP;
            end else begin
              tid_q <= sh_q[ID_WIDTH-1];
              sh_q  <= sh_q << 1;
              bit_q <= bit_q + 1'b1;
            end
          end
        end
        ST_GAP: begin
          if (gap_end) begin
            if (pend_v_q || req_ok) begin
              sh_q  <= ld_id;
              id_q  <= ld_id;
              src_q <= ld_src;
              st_q  <= ST_ARMED;
            end else begin
              busy_q <= 1'b0;
              st_q   <= ST_IDLE;
            end
          end else if (bnd) begin
            gap_q <= gap_q + 1'b1;
          end
        end
        default: st_q <= ST_IDLE;
      endcase

      if (busy_q && req_ok && !gap_free) begin
        if (!pend_v_q || pend_take) begin
          pend_q     <= trig_id_val;
          pend_src_q <= id_src;
          pend_v_q   <= 1'b1;
        end else if (drop_q != 8'hFF) begin
          drop_q <= drop_q + 8'd1;
        end
      end else if (pend_take) begin
        pend_v_q <= 1'b0;
      end
    end
  end

  assign trig_out   = trig_q;
  assign trig_id    = tid_q;
  assign busy       = busy_q;
  assign frame_done = done_q;
  assign id_sent    = sent_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_trig_id_tx.sv
// Directed self-checking bench for trig_id_tx.
// CLK_DIV=4, GAP_BITS=4, ID_WIDTH=16; bits captured on clk_out falls.
module tb_trig_id_tx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        src = 1'b0;
  logic [15:0] val = '0;
  logic        veto = 1'b0;
  logic        clk_out, trig_out, trig_id, busy, frame_done;
  logic [15:0] id_sent;
  logic [7:0]  drop_count;

  int n_run = 0;
  int n_fail = 0;

  trig_id_tx #(
    .CLK_DIV (4),
    .GAP_BITS(4),
    .ID_WIDTH(16)
  ) dut (
    .pll_clk    (clk),
    .reset      (rst_n),
    .trig_req   (req),
    .id_src     (src),
    .trig_id_val(val),
    .veto_in    (veto),
    .clk_out    (clk_out),
    .trig_out   (trig_out),
    .trig_id    (trig_id),
    .busy       (busy),
    .frame_done (frame_done),
    .id_sent    (id_sent),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] cap = '0;
  int          cap_n = 16;
  int          hi_tot = 0;
  int          done_tot = 0;
  int          last_rise = 0;
  logic        prev_to = 1'b0;
  logic        prev_co = 1'b0;

  always @(negedge clk) begin
    if (trig_out && !prev_to) begin
      cap       <= '0;
      cap_n     <= 0;
      last_rise <= cyc;
    end else if (prev_co && !clk_out && cap_n < 16) begin
      cap   <= {cap[14:0], trig_id};
      cap_n <= cap_n + 1;
    end
    if (trig_out) hi_tot <= hi_tot + 1;
    if (frame_done) done_tot <= done_tot + 1;
    prev_to <= trig_out;
    prev_co <= clk_out;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rise(output int t);
    int k = 0;
    while (!trig_out && k < 50) begin tick(); k++; end
    chk("rise_timeout", 32'(k < 50), 1);
    t = cyc;
  endtask

  task automatic wait_done(output int t);
    int k = 0;
    while (!frame_done && k < 300) begin tick(); k++; end
    chk("done_timeout", 32'(k < 300), 1);
    t = cyc;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 400) begin tick(); k++; end
    chk("idle_timeout", 32'(k < 400), 1);
  endtask

  task automatic run_frame(input string tag, input logic s,
                           input logic [15:0] v, input logic [15:0] e);
    int t;
    src = s; val = v; req = 1'b1;
    tick();
    req = 1'b0;
    wait_rise(t);
    wait_done(t);
    chk({tag, "_bits"}, 32'(cap), 32'(e));
    chk({tag, "_nbits"}, 32'(cap_n), 16);
    chk({tag, "_idsent"}, 32'(id_sent), 32'(e));
    wait_idle();
  endtask

  initial begin
    int rc, tr, td, h0, d0, r1, r2;

    // reset state
    #1;
    chk("rst_outs", 32'({clk_out, trig_out, trig_id, busy, frame_done}), 0);
    chk("rst_idsent", 32'(id_sent), 0);
    chk("rst_drop", 32'(drop_count), 0);
    #20;
    rst_n = 1'b1;
    chk("rel_clk0", 32'(clk_out), 0);
    tick();
    chk("rel_clk1", 32'(clk_out), 1);
    repeat (3) tick();

    // single external-ID frame
    h0 = hi_tot; d0 = done_tot;
    src = 1'b0; val = 16'hA5C3; req = 1'b1;
    tick();
    req = 1'b0;
    rc = cyc;
    wait_rise(tr);
    chk("latency", 32'((tr - rc) >= 1 && (tr - rc) <= 5), 1);
    wait_done(td);
    chk("a5c3_bits", 32'(cap), 32'h0000A5C3);
    chk("a5c3_idsent", 32'(id_sent), 32'h0000A5C3);
    chk("trig_width", 32'(hi_tot - h0), 4);
    chk("busy_at_done", 32'(busy), 1);
    tick();
    chk("done_pulse", 32'(frame_done), 0);
    chk("done_count", 32'(done_tot - d0), 1);
    repeat (14) tick();
    chk("busy_gap_end", 32'(busy), 1);
    tick();
    chk("busy_clear", 32'(busy), 0);

    // internal counter source, external frame does not advance it
    run_frame("cnt0", 1'b1, 16'hBEEF, 16'h0000);
    repeat (200) tick();
    run_frame("cnt1", 1'b1, 16'hBEEF, 16'h0001);
    run_frame("ext", 1'b0, 16'h1234, 16'h1234);
    run_frame("cnt2", 1'b1, 16'hBEEF, 16'h0002);

    // veto discards request, veto mid-frame leaves frame intact
    veto = 1'b1; val = 16'h9999; src = 1'b0; req = 1'b1;
    tick();
    req = 1'b0;
    repeat (10) tick();
    chk("veto_busy", 32'(busy), 0);
    chk("veto_drop", 32'(drop_count), 0);
    veto = 1'b0; val = 16'h5A0F; req = 1'b1;
    tick();
    req = 1'b0;
    wait_rise(tr);
    veto = 1'b1; val = 16'h0BAD; req = 1'b1;
    repeat (5) tick();
    req = 1'b0;
    wait_done(td);
    chk("vframe_bits", 32'(cap), 32'h00005A0F);
    wait_idle();
    repeat (10) tick();
    chk("vframe_nopend", 32'(busy), 0);
    chk("vframe_drop", 32'(drop_count), 0);
    veto = 1'b0;

    // one pending, one drop, pending respects gap
    src = 1'b0; val = 16'h1111; req = 1'b1;
    tick();
    req = 1'b0;
    repeat (9) tick();
    val = 16'h2222; req = 1'b1;
    tick();
    req = 1'b0;
    repeat (9) tick();
    val = 16'h3333; req = 1'b1;
    tick();
    req = 1'b0;
    d0 = done_tot;
    wait_done(td);
    r1 = last_rise;
    chk("q1_bits", 32'(cap), 32'h00001111);
    chk("q_drop", 32'(drop_count), 1);
    tick();
    wait_rise(r2);
    chk("q_gap", 32'((r2 - td) >= 16), 1);
    chk("q_spacing", 32'((r2 - r1) >= 64), 1);
    wait_done(td);
    chk("q2_bits", 32'(cap), 32'h00002222);
    chk("q2_idsent", 32'(id_sent), 32'h00002222);
    wait_idle();
    repeat (20) tick();
    chk("q_frames", 32'(done_tot - d0), 2);

    // reset mid-frame
    src = 1'b0; val = 16'hC0DE; req = 1'b1;
    tick();
    req = 1'b0;
    wait_rise(tr);
    repeat (32) tick();
    rst_n = 1'b0;
    #1;
    chk("mrst_outs", 32'({clk_out, trig_out, trig_id, busy, frame_done}), 0);
    chk("mrst_idsent", 32'(id_sent), 0);
    chk("mrst_drop", 32'(drop_count), 0);
    d0 = done_tot;
    repeat (3) tick();
    rst_n = 1'b1;
    chk("mrel_clk0", 32'(clk_out), 0);
    tick();
    chk("mrel_clk1", 32'(clk_out), 1);
    repeat (100) tick();
    chk("mrst_nodone", 32'(done_tot - d0), 0);
    run_frame("post_rst", 1'b0, 16'h3C96, 16'h3C96);
    run_frame("cnt_rst", 1'b1, 16'hBEEF, 16'h0000);

    // drop counter saturation
    src = 1'b0; val = 16'h7777; req = 1'b1;
    repeat (300) tick();
    req = 1'b0;
    chk("sat_drop", 32'(drop_count), 255);
    wait_idle();
    chk("sat_hold", 32'(drop_count), 255);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
